// File: rtl/div_unit.sv
// div_unit: multi-cycle unsigned restoring divider (DIVU), one quotient bit
// per clock. LO = quotient, HI = remainder, DZ flags a zero divisor.
module div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] RS,
  input  logic [WIDTH-1:0] RT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             DZ
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;       // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;

  logic [WIDTH:0]   r_shift;
  logic             r_ge;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step: the shifted remainder is WIDTH+1 bits so the compare
  // never overflows; after a successful subtract the result is below the
  // divisor, so the low WIDTH bits of the difference are exact.
  always_comb begin
    r_shift  = {rem, quo[WIDTH-1]};
    r_ge     = (r_shift >= {1'b0, dvs});
    r_diff   = r_shift[WIDTH-1:0] - dvs;
    rem_next = r_ge ? r_diff : r_shift[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], r_ge};
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and BUSY.
  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_next = (RT != '0) ? RUN : ZERO;
      end
      RUN: begin
        BUSY = 1'b1;
        if (cnt == '0) state_next = IDLE;
      end
      ZERO: begin
        BUSY       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      quo  <= '0;
      dvs  <= '0;
      rem  <= '0;
      LO   <= '0;
      HI   <= '0;
      DZ   <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            quo <= RS;
            dvs <= RT;
            rem <= '0;
            cnt <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            LO   <= quo_next;
            HI   <= rem_next;
            DZ   <= 1'b0;
            DONE <= 1'b1;
          end
        end
        ZERO: begin
          // quo still holds the captured dividend
          LO   <= '1;
          HI   <= quo;
          DZ   <= 1'b1;
          DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
